// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The slave modport is the arbiter view; master is the requester-plus-memory side.
interface dmem_arbiter_if;
    logic       req0, req1;
    logic       we0, we1;
    logic [7:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1;
    logic       ack0, ack1;
    logic       err0, err1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] mem_address;
    logic [7:0] mem_writeData;
    logic       mem_MemWrite;
    logic       mem_MemRead;
    logic [7:0] mem_readData;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_readData,
        output gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1,
        output mem_address, mem_writeData, mem_MemWrite, mem_MemRead
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_readData,
        input  gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1,
        input  mem_address, mem_writeData, mem_MemWrite, mem_MemRead
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter serialising req/ack transactions onto a single-port
// 32x8 data memory; each access takes IDLE -> SERVE -> DONE (one access per 3 cycles).
module dmem_arbiter #(
    parameter int DEPTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    state_t     r_state;
    state_t     w_next;
    logic       r_owner;
    logic       r_last_owner;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata0;
    logic [7:0] r_rdata1;

    logic       w_any_req;
    logic       w_pick;
    logic       w_in_range;
    logic       w_gnt;
    logic       w_done;
    logic       w_mem_write;
    logic       w_mem_read;
    logic [7:0] w_mem_address;
    logic [7:0] w_mem_writeData;
    logic [7:0] w_read_value;

    assign w_any_req  = bus.req0 | bus.req1;
    // On a contest the port that did not own the memory last time wins.
    assign w_pick     = (bus.req0 & bus.req1) ? ~r_last_owner : bus.req1;
    assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
    assign w_read_value = w_in_range ? bus.mem_readData : 8'h00;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next          = r_state;
        w_gnt           = 1'b0;
        w_done          = 1'b0;
        w_mem_write     = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_address   = 8'h00;
        w_mem_writeData = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next = SERVE;
                end
            end
            SERVE: begin
                w_gnt           = 1'b1;
                w_mem_address   = r_addr;
                w_mem_writeData = r_wdata;
                w_mem_write     = w_in_range & r_we;
                w_mem_read      = w_in_range & ~r_we;
                w_next          = DONE;
            end
            DONE: begin
                w_gnt  = 1'b1;
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= 8'h00;
            r_wdata      <= 8'h00;
            r_rdata0     <= 8'h00;
            r_rdata1     <= 8'h00;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_owner      <= w_pick;
                r_last_owner <= w_pick;
                r_we         <= w_pick ? bus.we1    : bus.we0;
                r_addr       <= w_pick ? bus.addr1  : bus.addr0;
                r_wdata      <= w_pick ? bus.wdata1 : bus.wdata0;
            end
            // Read data is captured at the SERVE-closing edge; out-of-range reads return zero.
            if (r_state == SERVE && !r_we) begin
                if (r_owner) begin
                    r_rdata1 <= w_read_value;
                end else begin
                    r_rdata0 <= w_read_value;
                end
            end
        end
    end

    assign bus.gnt0          = w_gnt & ~r_owner;
    assign bus.gnt1          = w_gnt &  r_owner;
    assign bus.ack0          = w_done & ~r_owner;
    assign bus.ack1          = w_done &  r_owner;
    assign bus.err0          = w_done & ~r_owner & ~w_in_range;
    assign bus.err1          = w_done &  r_owner & ~w_in_range;
    assign bus.rdata0        = r_rdata0;
    assign bus.rdata1        = r_rdata1;
    assign bus.mem_address   = w_mem_address;
    assign bus.mem_writeData = w_mem_writeData;
    assign bus.mem_MemWrite  = w_mem_write;
    assign bus.mem_MemRead   = w_mem_read;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32x8 memory; each scenario task
// drives its stimulus and compares against hand-computed values.
module tb_dmem_arbiter;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    bit   both_gnt_seen = 1'b0;
    logic [7:0] mem [0:31];

    dmem_arbiter_if bus();

    dmem_arbiter #(.DEPTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_MemWrite) mem[bus.mem_address[4:0]] = bus.mem_writeData;
    end

    assign bus.mem_readData = mem[bus.mem_address[4:0]];

    always @(negedge clk) begin
        if (bus.gnt0 && bus.gnt1) both_gnt_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err0, bus.err1} !== 6'b0) begin n_err++; $display("FAIL rst_flags: got %b want 000000", {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err0, bus.err1}); end
        n_cmp++; if ({bus.rdata0, bus.rdata1} !== 16'h0000) begin n_err++; $display("FAIL rst_rdata: got %h want 0000", {bus.rdata0, bus.rdata1}); end
        n_cmp++; if ({bus.mem_address, bus.mem_writeData, bus.mem_MemWrite, bus.mem_MemRead} !== 18'h0) begin n_err++; $display("FAIL rst_mem: got %h want 0", {bus.mem_address, bus.mem_writeData, bus.mem_MemWrite, bus.mem_MemRead}); end
        @(negedge clk) reset = 1'b1;
        tick();
        n_cmp++; if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1} !== 4'b0) begin n_err++; $display("FAIL rst_idle: got %b want 0000", {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1}); end
    endtask

    task automatic test_write_read();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'd5; bus.wdata0 = 8'hA5;
        tick();
        n_cmp++; if ({bus.gnt0, bus.mem_MemWrite, bus.mem_MemRead, bus.ack0} !== 4'b1100) begin n_err++; $display("FAIL wr_serve: gnt/we/re/ack got %b want 1100", {bus.gnt0, bus.mem_MemWrite, bus.mem_MemRead, bus.ack0}); end
        n_cmp++; if ({bus.mem_address, bus.mem_writeData} !== 16'h05A5) begin n_err++; $display("FAIL wr_bus: addr/data got %h want 05a5", {bus.mem_address, bus.mem_writeData}); end
        tick();
        n_cmp++; if ({bus.ack0, bus.err0, bus.mem_MemWrite} !== 3'b100) begin n_err++; $display("FAIL wr_done: ack/err/we got %b want 100", {bus.ack0, bus.err0, bus.mem_MemWrite}); end
        n_cmp++; if (mem[5] !== 8'hA5) begin n_err++; $display("FAIL wr_commit: mem[5] got %h want a5", mem[5]); end
        n_cmp++; if (bus.rdata0 !== 8'h00) begin n_err++; $display("FAIL wr_no_echo: rdata0 got %h want 00", bus.rdata0); end
        bus.req0 = 1'b0;
        tick();
        n_cmp++; if ({bus.ack0, bus.gnt0} !== 2'b00) begin n_err++; $display("FAIL wr_idle: ack/gnt got %b want 00", {bus.ack0, bus.gnt0}); end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd5;
        tick();
        n_cmp++; if ({bus.mem_MemRead, bus.mem_MemWrite, bus.mem_address} !== 10'b10_0000_0101) begin n_err++; $display("FAIL rd_serve: re/we/addr got %b want 1000000101", {bus.mem_MemRead, bus.mem_MemWrite, bus.mem_address}); end
        tick();
        n_cmp++; if ({bus.ack0, bus.rdata0} !== 9'h1A5) begin n_err++; $display("FAIL rd_done: ack/rdata0 got %h want 1a5", {bus.ack0, bus.rdata0}); end
        bus.req0 = 1'b0;
        tick();
    endtask

    task automatic test_contest();
        apply_reset();
        both_gnt_seen = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd3;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd20;
        tick();
        n_cmp++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin n_err++; $display("FAIL ct_first: gnt0/gnt1 got %b want 10", {bus.gnt0, bus.gnt1}); end
        tick();
        n_cmp++; if ({bus.ack0, bus.ack1, bus.rdata0} !== 10'b10_0000_0011) begin n_err++; $display("FAIL ct_ack0: ack0/ack1/rdata0 got %b want 1000000011", {bus.ack0, bus.ack1, bus.rdata0}); end
        bus.req0 = 1'b0;
        tick();
        tick();
        n_cmp++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin n_err++; $display("FAIL ct_second: gnt0/gnt1 got %b want 01", {bus.gnt0, bus.gnt1}); end
        tick();
        n_cmp++; if ({bus.ack1, bus.rdata1} !== 9'h1FC) begin n_err++; $display("FAIL ct_ack1: ack1/rdata1 got %h want 1fc", {bus.ack1, bus.rdata1}); end
        bus.req1 = 1'b0;
        tick();
        n_cmp++; if (both_gnt_seen !== 1'b0) begin n_err++; $display("FAIL ct_excl: both grants seen got %b want 0", both_gnt_seen); end
    endtask

    task automatic test_round_robin();
        int order[$];
        int times[$];
        both_gnt_seen = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd3;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd20;
        for (int c = 0; c < 30 && order.size() < 6; c++) begin
            tick();
            if (bus.ack0) begin order.push_back(0); times.push_back(c); end
            if (bus.ack1) begin order.push_back(1); times.push_back(c); end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        n_cmp++; if (order.size() != 6) begin n_err++; $display("FAIL rr_count: acks got %0d want 6 within 30 cycles", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            n_cmp++; if (order[i] != (i % 2)) begin n_err++; $display("FAIL rr_order[%0d]: port got %0d want %0d", i, order[i], i % 2); end
        end
        for (int i = 1; i < times.size(); i++) begin
            n_cmp++; if (times[i] - times[i-1] != 3) begin n_err++; $display("FAIL rr_spacing[%0d]: cycles got %0d want 3", i, times[i] - times[i-1]); end
        end
        n_cmp++; if ({bus.rdata0, bus.rdata1} !== 16'h03FC) begin n_err++; $display("FAIL rr_rdata: got %h want 03fc", {bus.rdata0, bus.rdata1}); end
        n_cmp++; if (both_gnt_seen !== 1'b0) begin n_err++; $display("FAIL rr_excl: both grants seen got %b want 0", both_gnt_seen); end
        tick();
        tick();
    endtask

    task automatic test_out_of_range();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'd40; bus.wdata1 = 8'h55;
        tick();
        n_cmp++; if ({bus.gnt1, bus.mem_MemWrite, bus.mem_MemRead} !== 3'b100) begin n_err++; $display("FAIL oor_wr_serve: gnt1/we/re got %b want 100", {bus.gnt1, bus.mem_MemWrite, bus.mem_MemRead}); end
        tick();
        n_cmp++; if ({bus.ack1, bus.err1, bus.mem_MemWrite} !== 3'b110) begin n_err++; $display("FAIL oor_wr_done: ack1/err1/we got %b want 110", {bus.ack1, bus.err1, bus.mem_MemWrite}); end
        n_cmp++; if (mem[8] !== 8'h08) begin n_err++; $display("FAIL oor_wr_mem: mem[8] got %h want 08", mem[8]); end
        bus.req1 = 1'b0;
        tick();
        n_cmp++; if ({bus.ack1, bus.err1} !== 2'b00) begin n_err++; $display("FAIL oor_err_pulse: ack1/err1 got %b want 00", {bus.ack1, bus.err1}); end
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd40;
        tick();
        n_cmp++; if ({bus.mem_MemRead, bus.mem_MemWrite} !== 2'b00) begin n_err++; $display("FAIL oor_rd_serve: re/we got %b want 00", {bus.mem_MemRead, bus.mem_MemWrite}); end
        tick();
        n_cmp++; if ({bus.ack1, bus.err1, bus.rdata1} !== 10'b11_0000_0000) begin n_err++; $display("FAIL oor_rd_done: ack1/err1/rdata1 got %b want 1100000000", {bus.ack1, bus.err1, bus.rdata1}); end
        bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_drop_req();
        int n_ack;
        int n_gnt;
        n_ack = 0;
        n_gnt = 0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd6;
        tick();
        n_cmp++; if (bus.gnt0 !== 1'b1) begin n_err++; $display("FAIL drop_gnt: gnt0 got %b want 1", bus.gnt0); end
        bus.req0 = 1'b0;
        tick();
        n_cmp++; if ({bus.ack0, bus.rdata0} !== 9'h106) begin n_err++; $display("FAIL drop_ack: ack0/rdata0 got %h want 106", {bus.ack0, bus.rdata0}); end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.ack0) n_ack++;
            if (bus.gnt0 || bus.mem_MemRead || bus.mem_MemWrite) n_gnt++;
        end
        n_cmp++; if (n_ack != 0) begin n_err++; $display("FAIL drop_extra_ack: acks got %0d want 0", n_ack); end
        n_cmp++; if (n_gnt != 0) begin n_err++; $display("FAIL drop_extra_access: busy cycles got %0d want 0", n_gnt); end
    endtask

    task automatic test_reset_mid_serve();
        int n_ack;
        n_ack = 0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd7;
        tick();
        n_cmp++; if (bus.mem_MemRead !== 1'b1) begin n_err++; $display("FAIL rms_serve: MemRead got %b want 1", bus.mem_MemRead); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({bus.mem_address, bus.mem_writeData, bus.mem_MemWrite, bus.mem_MemRead} !== 18'h0) begin n_err++; $display("FAIL rms_mem: got %h want 0", {bus.mem_address, bus.mem_writeData, bus.mem_MemWrite, bus.mem_MemRead}); end
        n_cmp++; if ({bus.gnt0, bus.ack0, bus.rdata0} !== 10'b0) begin n_err++; $display("FAIL rms_port0: gnt0/ack0/rdata0 got %b want 0", {bus.gnt0, bus.ack0, bus.rdata0}); end
        bus.req0 = 1'b0;
        @(negedge clk) reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.ack0) n_ack++;
        end
        n_cmp++; if (n_ack != 0) begin n_err++; $display("FAIL rms_no_ack: acks got %0d want 0", n_ack); end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd7;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd20;
        tick();
        n_cmp++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin n_err++; $display("FAIL rms_contest: gnt0/gnt1 got %b want 10", {bus.gnt0, bus.gnt1}); end
        tick();
        n_cmp++; if ({bus.ack0, bus.rdata0} !== 9'h107) begin n_err++; $display("FAIL rms_ack: ack0/rdata0 got %h want 107", {bus.ack0, bus.rdata0}); end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        mem[20] = 8'hFC;

        test_reset();
        test_write_read();
        test_contest();
        test_round_robin();
        test_out_of_range();
        test_drop_req();
        test_reset_mid_serve();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
